// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the decode-stage immediate generator.
package imm_gen_pkg;

    // Immediate format reported alongside every decoded result.
    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_R     = 3'd1,
        FMT_I     = 3'd2,
        FMT_SHIFT = 3'd3,
        FMT_S     = 3'd4,
        FMT_B     = 3'd5,
        FMT_U     = 3'd6,
        FMT_J     = 3'd7
    } imm_fmt_t;

    // Major opcodes (instruction[6:0]) that carry or imply an immediate.
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // funct3 values that turn an OP_IMM instruction into a shift.
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SRXI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction -> sign-extended
// immediate, format code and an "unsupported opcode" flag.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SUPPORT_UJ = 1,
    parameter int SHAMT_ZEXT = 1
) (
    input  logic [31:0]           instruction_i,
    output logic [DATA_WIDTH-1:0] immediate_o,
    output imm_fmt_t              imm_fmt_o,
    output logic                  unsupported_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        sign;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [31:0] shamt;
    logic [31:0] raw32;

    assign opcode = instruction_i[6:0];
    assign funct3 = instruction_i[14:12];
    assign sign   = instruction_i[31];

    // Every format's value fits in 32 bits as a signed number; widening to
    // DATA_WIDTH is a single sign extension at the output.
    assign i_imm = {{20{sign}}, instruction_i[31:20]};
    assign s_imm = {{20{sign}}, instruction_i[31:25], instruction_i[11:7]};
    assign b_imm = {{19{sign}}, instruction_i[31], instruction_i[7],
                    instruction_i[30:25], instruction_i[11:8], 1'b0};
    assign u_imm = {instruction_i[31:12], 12'b0};
    assign j_imm = {{11{sign}}, instruction_i[31], instruction_i[19:12],
                    instruction_i[20], instruction_i[30:21], 1'b0};

    // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one; both are non-negative
    // so the common sign extension below leaves them zero-extended.
    always_comb begin
        shamt = '0;
        if (DATA_WIDTH == 64) begin
            shamt = {26'b0, instruction_i[25:20]};
        end else begin
            shamt = {27'b0, instruction_i[24:20]};
        end
    end

    // Select the format and its raw 32-bit signed value from the opcode.
    always_comb begin
        raw32         = '0;
        imm_fmt_o     = FMT_NONE;
        unsupported_o = 1'b0;
        case (opcode)
            OP_IMM: begin
                if ((SHAMT_ZEXT != 0) && ((funct3 == F3_SLLI) || (funct3 == F3_SRXI))) begin
                    imm_fmt_o = FMT_SHIFT;
                    raw32     = shamt;
                end else begin
                    imm_fmt_o = FMT_I;
                    raw32     = i_imm;
                end
            end
            OP_LOAD, OP_JALR: begin
                imm_fmt_o = FMT_I;
                raw32     = i_imm;
            end
            OP_STORE: begin
                imm_fmt_o = FMT_S;
                raw32     = s_imm;
            end
            OP_BRANCH: begin
                imm_fmt_o = FMT_B;
                raw32     = b_imm;
            end
            OP_LUI, OP_AUIPC: begin
                if (SUPPORT_UJ != 0) begin
                    imm_fmt_o = FMT_U;
                    raw32     = u_imm;
                end else begin
                    unsupported_o = 1'b1;
                end
            end
            OP_JAL: begin
                if (SUPPORT_UJ != 0) begin
                    imm_fmt_o = FMT_J;
                    raw32     = j_imm;
                end else begin
                    unsupported_o = 1'b1;
                end
            end
            OP_REG: begin
                imm_fmt_o = FMT_R;
            end
            default: begin
                unsupported_o = 1'b1;
            end
        endcase
    end

    // Sign extension replicates instruction[31] (bit 31 of raw32) upward.
    assign immediate_o = DATA_WIDTH'($signed(raw32));

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: combinational decode feeding an output
// register backed by one skid entry, with flush and synchronous reset.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready depends only on rst_n and the skid entry, never on
// in_valid; out_valid/data stay stable while out_valid is 1 and out_ready is 0.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SUPPORT_UJ = 1,
    parameter int SHAMT_ZEXT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] immediate,
    output logic [2:0]            imm_fmt,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic                  unsupported
);

    logic [DATA_WIDTH-1:0] dec_imm;
    imm_fmt_t              dec_fmt;
    logic                  dec_unsup;

    imm_decode #(
        .DATA_WIDTH (DATA_WIDTH),
        .SUPPORT_UJ (SUPPORT_UJ),
        .SHAMT_ZEXT (SHAMT_ZEXT)
    ) u_decode (
        .instruction_i (instruction),
        .immediate_o   (dec_imm),
        .imm_fmt_o     (dec_fmt),
        .unsupported_o (dec_unsup)
    );

    // Output register (head of the stage).
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_imm_q,   out_imm_d;
    imm_fmt_t              out_fmt_q,   out_fmt_d;
    logic [DATA_WIDTH-1:0] out_pc_q,    out_pc_d;
    logic                  out_unsup_q, out_unsup_d;

    // Skid entry: holds the one instruction accepted while the head stalled.
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_imm_q,   skid_imm_d;
    imm_fmt_t              skid_fmt_q,   skid_fmt_d;
    logic [DATA_WIDTH-1:0] skid_pc_q,    skid_pc_d;
    logic                  skid_unsup_q, skid_unsup_d;

    logic accept;
    logic out_free;

    assign in_ready = rst_n & ~skid_valid_q;
    // A flush drops the same-cycle instruction even when in_ready is high.
    assign accept   = in_valid & in_ready & ~flush;
    // Head can take a new entry when empty or leaving this cycle.
    assign out_free = ~out_valid_q | out_ready;

    // Next-state for head and skid entry; data holds unless overwritten.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_fmt_d    = out_fmt_q;
        out_pc_d     = out_pc_q;
        out_unsup_d  = out_unsup_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_fmt_d   = skid_fmt_q;
        skid_pc_d    = skid_pc_q;
        skid_unsup_d = skid_unsup_q;

        if (flush) begin
            // Invalidate both entries; data keeps stale values.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full implies head full and in_ready low: only a drain
            // can happen, after which the skid entry moves up.
            if (out_ready) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_fmt_d    = skid_fmt_q;
                out_pc_d     = skid_pc_q;
                out_unsup_d  = skid_unsup_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (out_free) begin
                // Head empty or draining: new entry bypasses the skid.
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_fmt_d   = dec_fmt;
                out_pc_d    = pc_in;
                out_unsup_d = dec_unsup;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_fmt_d   = dec_fmt;
                skid_pc_d    = pc_in;
                skid_unsup_d = dec_unsup;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset clearing everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_NONE;
            out_pc_q     <= '0;
            out_unsup_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_NONE;
            skid_pc_q    <= '0;
            skid_unsup_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_fmt_q    <= out_fmt_d;
            out_pc_q     <= out_pc_d;
            out_unsup_q  <= out_unsup_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_fmt_q   <= skid_fmt_d;
            skid_pc_q    <= skid_pc_d;
            skid_unsup_q <= skid_unsup_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign immediate   = out_imm_q;
    assign imm_fmt     = out_fmt_q;
    assign pc_out      = out_pc_q;
    assign unsupported = out_unsup_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three parameterisations share one input stream;
// a two-deep FIFO model plus an arithmetic immediate model predict outputs.
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [63:0] pc;

    // dut_a: DW=32, U/J on, shift zext on
    logic        a_in_ready, a_out_valid, a_unsup;
    logic [31:0] a_imm, a_pc_out;
    logic [2:0]  a_fmt;
    // dut_n: DW=32, U/J off, shift zext off
    logic        n_in_ready, n_out_valid, n_unsup;
    logic [31:0] n_imm, n_pc_out;
    logic [2:0]  n_fmt;
    // dut_w: DW=64, U/J on, shift zext on
    logic        w_in_ready, w_out_valid, w_unsup;
    logic [63:0] w_imm, w_pc_out;
    logic [2:0]  w_fmt;

    imm_gen_stage #(.DATA_WIDTH(32), .SUPPORT_UJ(1), .SHAMT_ZEXT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(a_in_ready), .instruction(instruction), .pc_in(pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .immediate(a_imm),
        .imm_fmt(a_fmt), .pc_out(a_pc_out), .unsupported(a_unsup)
    );

    imm_gen_stage #(.DATA_WIDTH(32), .SUPPORT_UJ(0), .SHAMT_ZEXT(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(n_in_ready), .instruction(instruction), .pc_in(pc[31:0]),
        .out_valid(n_out_valid), .out_ready(out_ready), .immediate(n_imm),
        .imm_fmt(n_fmt), .pc_out(n_pc_out), .unsupported(n_unsup)
    );

    imm_gen_stage #(.DATA_WIDTH(64), .SUPPORT_UJ(1), .SHAMT_ZEXT(1)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(w_in_ready), .instruction(instruction), .pc_in(pc),
        .out_valid(w_out_valid), .out_ready(out_ready), .immediate(w_imm),
        .imm_fmt(w_fmt), .pc_out(w_pc_out), .unsupported(w_unsup)
    );

    // ---------------- scoreboard ----------------
    int vectors     = 0;
    int miscompares = 0;
    // Entries held by the stage, oldest first: {pc, instruction}.
    logic [95:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Immediate value computed as a plain integer from the field weights.
    function automatic void ref_decode(input logic [31:0] ins, input int dw, input bit uj,
                                       input bit zx, output logic [63:0] imm,
                                       output logic [2:0] fmt, output logic unsup);
        longint v = 0;
        int     f3 = int'(ins[14:12]);
        fmt   = FMT_NONE;
        unsup = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                if (ins[6:0] == 7'h13 && zx && (f3 == 1 || f3 == 5)) begin
                    fmt = FMT_SHIFT;
                    v   = (dw == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
                end else begin
                    fmt = FMT_I;
                    v   = longint'(ins[31:20]);
                    if (ins[31]) v -= 4096;
                end
            end
            7'h23: begin
                fmt = FMT_S;
                v   = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
                if (ins[31]) v -= 4096;
            end
            7'h63: begin
                fmt = FMT_B;
                v   = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
                if (ins[31]) v -= 4096;
            end
            7'h37, 7'h17: begin
                if (uj) begin
                    fmt = FMT_U;
                    v   = longint'(ins[31:12]) * 4096;
                    if (ins[31]) v -= 64'sh1_0000_0000;
                end else begin
                    unsup = 1'b1;
                end
            end
            7'h6F: begin
                if (uj) begin
                    fmt = FMT_J;
                    v   = longint'(ins[30:21]) * 2 + longint'(ins[20]) * 2048
                        + longint'(ins[19:12]) * 4096;
                    if (ins[31]) v -= 1048576;
                end else begin
                    unsup = 1'b1;
                end
            end
            7'h33: fmt = FMT_R;
            default: unsup = 1'b1;
        endcase
        imm = 64'(v);
        if (dw == 32) imm[63:32] = 32'h0;
    endfunction

    task automatic check_dut(input string name, input logic [63:0] imm_got, input logic [2:0] fmt_got,
                             input logic unsup_got, input logic [63:0] pc_got,
                             input int dw, input bit uj, input bit zx);
        logic [63:0] e_imm;
        logic [2:0]  e_fmt;
        logic        e_un;
        logic [63:0] e_pc;
        ref_decode(exp_q[0][31:0], dw, uj, zx, e_imm, e_fmt, e_un);
        e_pc = exp_q[0][95:32];
        if (dw == 32) e_pc[63:32] = 32'h0;
        check_eq({name, ".immediate"}, imm_got, e_imm);
        check_eq({name, ".imm_fmt"}, 64'(fmt_got), 64'(e_fmt));
        check_eq({name, ".unsupported"}, 64'(unsup_got), 64'(e_un));
        check_eq({name, ".pc_out"}, pc_got, e_pc);
    endtask

    task automatic check_outputs();
        logic e_valid;
        logic e_ready;
        e_valid = (exp_q.size() > 0);
        e_ready = rst_n && (exp_q.size() < 2);
        check_eq("a.out_valid", 64'(a_out_valid), 64'(e_valid));
        check_eq("n.out_valid", 64'(n_out_valid), 64'(e_valid));
        check_eq("w.out_valid", 64'(w_out_valid), 64'(e_valid));
        check_eq("a.in_ready", 64'(a_in_ready), 64'(e_ready));
        check_eq("n.in_ready", 64'(n_in_ready), 64'(e_ready));
        check_eq("w.in_ready", 64'(w_in_ready), 64'(e_ready));
        if (e_valid) begin
            check_dut("a", 64'(a_imm), a_fmt, a_unsup, 64'(a_pc_out), 32, 1'b1, 1'b1);
            check_dut("n", 64'(n_imm), n_fmt, n_unsup, 64'(n_pc_out), 32, 1'b0, 1'b0);
            check_dut("w", w_imm, w_fmt, w_unsup, w_pc_out, 64, 1'b1, 1'b1);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive, check current outputs, advance the model, clock.
    task automatic cycle(input logic [31:0] ins, input logic [63:0] pcv, input logic iv,
                         input logic ordy, input logic fl, input logic rn);
        instruction = ins;
        pc          = pcv;
        in_valid    = iv;
        out_ready   = ordy;
        flush       = fl;
        rst_n       = rn;
        #2;
        check_outputs();
        if (!rn || fl) begin
            exp_q.delete();
        end else begin
            bit can_in = (exp_q.size() < 2);
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (iv && can_in) exp_q.push_back({pcv, ins});
        end
        @(posedge clk);
        #1;
    endtask

    // Directed check of dut_a's registered outputs against fixed values.
    task automatic check_a(input string tag, input logic [31:0] imm, input logic [2:0] fmt,
                           input logic un, input logic [31:0] pcv);
        check_eq({tag, ".imm"}, 64'(a_imm), 64'(imm));
        check_eq({tag, ".fmt"}, 64'(a_fmt), 64'(fmt));
        check_eq({tag, ".unsup"}, 64'(a_unsup), 64'(un));
        check_eq({tag, ".pc"}, 64'(a_pc_out), 64'(pcv));
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] dir_ins [8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7,
                                 32'h001000EF, 32'h4030D093, 32'h0000007F, 32'h00000033};
    logic [31:0] dir_imm [8] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000,
                                 32'h00000800, 32'h00000003, 32'h00000000, 32'h00000000};
    logic [2:0]  dir_fmt [8] = '{FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SHIFT, FMT_NONE, FMT_R};
    logic        dir_un  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0]  ops     [10] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

    localparam logic [31:0] INS_A = 32'h00500093; // addi imm 5
    localparam logic [31:0] INS_B = 32'h00A00113; // addi imm 10
    localparam logic [31:0] INS_C = 32'h01400193; // addi imm 20
    localparam logic [31:0] INS_D = 32'h06300213; // addi imm 99
    localparam logic [31:0] INS_E = 32'h7FF00293; // addi imm 2047

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        instruction = 32'h0;
        pc          = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values
        check_eq("rst.out_valid", 64'(a_out_valid), 64'h0);
        check_eq("rst.in_ready", 64'(a_in_ready), 64'h0);
        check_a("rst", 32'h0, FMT_NONE, 1'b0, 32'h0);
        check_eq("rst.w_imm", w_imm, 64'h0);

        // Format decode, one per cycle, out_ready=1
        for (int i = 0; i < 8; i++) begin
            cycle(dir_ins[i], 64'h1000 + 64'(4 * i), 1'b1, 1'b1, 1'b0, 1'b1);
            check_eq("dir.valid", 64'(a_out_valid), 64'h1);
            check_a("dir", dir_imm[i], dir_fmt[i], dir_un[i], 32'h1000 + 32'(4 * i));
        end
        cycle(32'h123452B7, 64'h2000, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("nouj.imm", 64'(n_imm), 64'h0);
        check_eq("nouj.fmt", 64'(n_fmt), 64'(FMT_NONE));
        check_eq("nouj.unsup", 64'(n_unsup), 64'h1);
        cycle(32'hFFF00093, 64'hDEAD_0000_0000_2004, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("w64.i_imm", w_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("w64.pc", w_pc_out, 64'hDEAD_0000_0000_2004);
        cycle(32'h001000EF, 64'h2008, 1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("w64.j_imm", w_imm, 64'h0000_0000_0000_0800);
        cycle(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Backpressure: A held, B in skid, C refused, then in-order drain
        cycle(INS_A, 64'h200, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(INS_B, 64'h204, 1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("bp.in_ready", 64'(a_in_ready), 64'h0);
        cycle(INS_C, 64'h208, 1'b1, 1'b0, 1'b0, 1'b1);
        check_a("bp.hold", 32'd5, FMT_I, 1'b0, 32'h200);
        cycle(INS_C, 64'h208, 1'b1, 1'b1, 1'b0, 1'b1);
        check_a("bp.b", 32'd10, FMT_I, 1'b0, 32'h204);
        cycle(INS_C, 64'h208, 1'b1, 1'b1, 1'b0, 1'b1);
        check_a("bp.c", 32'd20, FMT_I, 1'b0, 32'h208);
        cycle(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("bp.empty", 64'(a_out_valid), 64'h0);

        // Flush with skid full and a same-cycle instruction
        cycle(INS_A, 64'h300, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(INS_B, 64'h304, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(INS_D, 64'h308, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("fl.out_valid", 64'(a_out_valid), 64'h0);
        check_eq("fl.in_ready", 64'(a_in_ready), 64'h1);
        repeat (2) cycle(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Reset mid-stall discards both entries and zeroes data
        cycle(INS_A, 64'h400, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(INS_B, 64'h404, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle(INS_C, 64'h408, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("mr.out_valid", 64'(a_out_valid), 64'h0);
        check_a("mr", 32'h0, FMT_NONE, 1'b0, 32'h0);
        check_eq("mr.w_imm", w_imm, 64'h0);
        cycle(INS_E, 64'h40C, 1'b1, 1'b1, 1'b0, 1'b1);
        check_a("mr.e", 32'd2047, FMT_I, 1'b0, 32'h40C);
        cycle(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("mr.alone", 64'(a_out_valid), 64'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            int          k;
            ins = $urandom;
            k   = $urandom_range(0, 10);
            if (k < 10) ins[6:0] = ops[k];
            cycle(ins, {32'($urandom), 32'($urandom)},
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 200) != 0));
        end
        repeat (3) cycle(32'h0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
